rf_write_arbiter: RTL and testbench
===================================

Name:
rf_write_arbiter

Overview:
- Shares the single write port of the 16x16 register file among NUM_REQ independent requesters.
- Uses round-robin arbitration and a request/grant handshake.
- Includes a bulk-clear sequencer that zeroes all registers through the normal write port, one address per cycle.
- Drives the register file's write, address and data inputs from registered outputs. These change on the rising edge of clk, so they are stable when the register file samples them on the falling edge.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8)
- ADDR_W, 4, register address width
- DATA_W, 16, register data width
- NUM_REGS, 16, number of registers swept by a clear; must equal 2**ADDR_W

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester write request, held until granted
- req_addr  input  NUM_REQ*ADDR_W  flattened target addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  flattened write data; requester i uses bits [i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  combinational one-hot grant; the write is accepted at the rising edge where req[i] && gnt[i]
- clear_start  input  1  single-cycle pulse requesting a zero-sweep of all registers
- busy  output  1  high while a clear is in progress
- clear_done  output  1  registered one-cycle pulse after the last clear write is issued
- rf_write  output  1  registered write enable to the register file
- rf_address  output  ADDR_W  registered write address
- rf_data  output  DATA_W  registered write data

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, rr_ptr=0, clear_cnt=0.
  - rf_write=0, rf_address=0, rf_data=0.
  - busy=0, clear_done=0; gnt=0 while reset is low.
  - Reset mid-clear aborts the sweep immediately; no further clear writes are issued.
- States: IDLE and CLEAR.
- IDLE, grant logic (combinational):
  - If clear_start=1, gnt=0: the clear wins, and no request is accepted that cycle.
  - Otherwise gnt selects the first requester i with req[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - gnt=0 when req=0.
- IDLE, rising edge with a grant to requester i:
  - rf_write<=1, rf_address<=req_addr[i], rf_data<=req_data[i].
  - rr_ptr<=(i+1) mod NUM_REQ.
- IDLE, rising edge with no grant: rf_write<=0; rf_address and rf_data hold their last value.
- Write latency: the accepting edge is t; rf_write is high from t until t+1; the register file captures the data at the falling edge between them.
- Throughput: one write per cycle. Back-to-back grants are allowed, to the same or different requesters.
- IDLE with clear_start=1 at an edge:
  - state<=CLEAR, clear_cnt<=1, busy<=1.
  - rf_write<=1, rf_address<=0, rf_data<=0.
- CLEAR, each edge:
  - rf_write<=1, rf_address<=clear_cnt, rf_data<=0, clear_cnt<=clear_cnt+1.
  - gnt=0 throughout; requests stay pending.
  - clear_start is ignored.
- CLEAR, edge that issues address NUM_REGS-1: the next edge returns to IDLE.
  - busy<=0, clear_done<=1 for exactly one cycle, rf_write<=0.
  - Arbitration resumes in that same next cycle.
- clear_cnt wraps naturally at NUM_REGS; it is never used beyond NUM_REGS-1.
- A clear produces exactly NUM_REGS consecutive writes: addresses 0..NUM_REGS-1, data 0.
- rr_ptr is not changed by a clear.
- A requester that drops req before being granted is simply not served; there is no error.
- Simultaneous requests to the same address from different requesters are serialised in round-robin order; the last granted write wins.
- The arbiter does not check address range; the address passes through unchanged.

Test Plan:
- Reset, then req=4'b0001, addr0=5, data0=16'hBEEF:
  - gnt=4'b0001 immediately.
  - Next cycle: rf_write=1, rf_address=5, rf_data=16'hBEEF.
  - Register 5 reads 16'hBEEF after the falling edge.
  - rr_ptr=1.
- req=4'b1111 held, with distinct addresses/data, rr_ptr=0:
  - Grants in order 0,1,2,3 on four consecutive edges; rf_write high for four cycles.
  - Each request is dropped when granted.
- rr_ptr=3 (after granting requester 2), req=4'b1001:
  - Requester 3 is granted first, then requester 0.
  - Then with req=4'b0101: requester 0 is not granted before requester 2.
- clear_start pulse in IDLE with all registers preloaded non-zero:
  - busy high for 16 cycles; rf_address 0..15; rf_data=0.
  - clear_done pulses in the cycle after address 15 is issued.
  - All 16 registers read 0 afterwards.
- clear_start and req=4'b0010 in the same cycle:
  - gnt=0 that cycle and through the clear.
  - Requester 1 is granted in the cycle clear_done is high.
  - Its write lands after the sweep.
- Assert reset low after address 7 of a clear:
  - busy, rf_write and clear_done drop to 0 immediately.
  - Registers 8..15 keep their prior values.
  - After release, a new request is granted normally.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a bulk-clear sequencer
// that sweeps zeros through every address using the same registered write outputs.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      clear_start,
  output logic                      busy,
  output logic                      clear_done,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_address,
  output logic [DATA_W-1:0]         rf_data
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   clear_cnt_q, clear_cnt_d;
  logic                rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]   rf_address_q, rf_address_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;
  logic                busy_q, busy_d;
  logic                clear_done_q, clear_done_d;

  logic                gnt_valid;
  logic [PtrW-1:0]     gnt_idx;
  int unsigned         idx;

  // Search starts at rr_ptr and wraps; gated off during reset, clear, or a clear request.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    gnt       = '0;
    if (reset && (state_q == StIdle) && !clear_start) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(rr_ptr_q) + k) % NUM_REQ;
        if (!gnt_valid && req[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx[PtrW-1:0];
        end
      end
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    clear_cnt_d  = clear_cnt_q;
    rf_write_d   = 1'b0;
    rf_address_d = rf_address_q;
    rf_data_d    = rf_data_q;
    busy_d       = busy_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d      = StClear;
          clear_cnt_d  = ADDR_W'(1);
          busy_d       = 1'b1;
          rf_write_d   = 1'b1;
          rf_address_d = '0;
          rf_data_d    = '0;
        end else if (gnt_valid) begin
          rf_write_d   = 1'b1;
          rf_address_d = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
          rf_data_d    = req_data[32'(gnt_idx)*DATA_W +: DATA_W];
          rr_ptr_d     = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      StClear: begin
        // The last address went out on the previous edge; finish the sweep.
        if (rf_address_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d      = StIdle;
          busy_d       = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          rf_write_d   = 1'b1;
          rf_address_d = clear_cnt_q;
          rf_data_d    = '0;
          clear_cnt_d  = clear_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      clear_cnt_q  <= '0;
      rf_write_q   <= 1'b0;
      rf_address_q <= '0;
      rf_data_q    <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      clear_cnt_q  <= clear_cnt_d;
      rf_write_q   <= rf_write_d;
      rf_address_q <= rf_address_d;
      rf_data_q    <= rf_data_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign rf_write   = rf_write_q;
  assign rf_address = rf_address_q;
  assign rf_data    = rf_data_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a queue of expected writes is checked against the write
// port, which also feeds a behavioural 16x16 register file sampled on the falling edge.
module tb_rf_write_arbiter;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req_v;
  logic [3:0]  addr_a [4];
  logic [15:0] data_a [4];
  logic [15:0] req_addr_f;
  logic [63:0] req_data_f;
  logic [3:0]  gnt;
  logic        clear_start;
  logic        busy;
  logic        clear_done;
  logic        rf_write;
  logic [3:0]  rf_address;
  logic [15:0] rf_data;

  logic [15:0] rf_mem [16];
  wr_t         exp_q [$];
  int          checks = 0;
  int          errors = 0;

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign req_addr_f[i*4 +: 4]   = addr_a[i];
    assign req_data_f[i*16 +: 16] = data_a[i];
  end

  rf_write_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (4),
    .DATA_W  (16),
    .NUM_REGS(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req_v),
    .req_addr   (req_addr_f),
    .req_data   (req_data_f),
    .gnt        (gnt),
    .clear_start(clear_start),
    .busy       (busy),
    .clear_done (clear_done),
    .rf_write   (rf_write),
    .rf_address (rf_address),
    .rf_data    (rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register file model and scoreboard pop, both on the falling edge.
  always @(negedge clk) begin
    if (reset && rf_write) begin
      rf_mem[rf_address] <= rf_data;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(rf_address), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(rf_address), 32'(e.a));
        check("wr_data", 32'(rf_data), 32'(e.d));
      end
    end
  end

  // Call just after a rising edge with req_v set; checks the grant, then drops it once accepted.
  task automatic grant_step(input logic [3:0] exp_g);
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(exp_g));
    for (int i = 0; i < 4; i++) begin
      if (exp_g[i]) exp_q.push_back('{a: addr_a[i], d: data_a[i]});
    end
    @(posedge clk);
    #1;
    req_v = req_v & ~exp_g;
  endtask

  task automatic preload(input logic [15:0] base);
    for (int a = 0; a < 16; a++) begin
      addr_a[0] = 4'(a);
      data_a[0] = base + 16'(a);
      req_v     = 4'b0001;
      grant_step(4'b0001);
    end
  endtask

  // Clear sweep, optionally with a request raised in the same cycle as clear_start.
  task automatic run_clear(input logic [3:0] pend);
    req_v       = pend;
    clear_start = 1'b1;
    @(negedge clk);
    check("clr_gnt0", 32'(gnt), 32'h0);
    for (int a = 0; a < 16; a++) exp_q.push_back('{a: 4'(a), d: 16'h0});
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) exp_q.push_back('{a: addr_a[i], d: data_a[i]});
    end
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("clr_busy", 32'(busy), 32'h1);
      check("clr_addr", 32'(rf_address), 32'(c));
      check("clr_gnt", 32'(gnt), 32'h0);
      check("clr_done_early", 32'(clear_done), 32'h0);
    end
    @(negedge clk);
    check("clr_busy_end", 32'(busy), 32'h0);
    check("clr_done", 32'(clear_done), 32'h1);
    check("clr_wr_end", 32'(rf_write), 32'h0);
    check("clr_gnt_resume", 32'(gnt), 32'(pend));
    @(posedge clk);
    #1;
    req_v = 4'b0000;
    @(negedge clk);
    check("clr_done_pulse", 32'(clear_done), 32'h0);
  endtask

  initial begin
    reset       = 1'b0;
    clear_start = 1'b0;
    req_v       = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 4'(i);
      data_a[i] = 16'h0;
    end
    for (int a = 0; a < 16; a++) rf_mem[a] = 16'h0;

    // Reset state, with requests asserted across two rising edges
    #17;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr", 32'(rf_write), 32'h0);
    check("rst_addr", 32'(rf_address), 32'h0);
    check("rst_data", 32'(rf_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(clear_done), 32'h0);
    req_v = 4'b0000;
    #5 reset = 1'b1;

    // Single write
    @(posedge clk);
    #1;
    addr_a[0] = 4'd5;
    data_a[0] = 16'hBEEF;
    req_v     = 4'b0001;
    grant_step(4'b0001);
    @(negedge clk);
    #1;
    check("reg5", 32'(rf_mem[5]), 32'hBEEF);

    // All four requesting; rr_ptr is 1 after the first write
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 4'(10 + i);
      data_a[i] = 16'hA000 + 16'(i);
    end
    req_v = 4'b1111;
    grant_step(4'b0010);
    grant_step(4'b0100);
    grant_step(4'b1000);
    grant_step(4'b0001);

    // Grant 2 moves rr_ptr to 3; then 1001 serves 3 before 0, and 0101 serves 2 before 0
    req_v = 4'b0100;
    grant_step(4'b0100);
    req_v = 4'b1001;
    grant_step(4'b1000);
    grant_step(4'b0001);
    req_v = 4'b0101;
    grant_step(4'b0100);
    grant_step(4'b0001);

    // Clear over a fully non-zero file
    preload(16'h1000);
    run_clear(4'b0000);
    for (int a = 0; a < 16; a++) check("clr_reg_zero", 32'(rf_mem[a]), 32'h0);

    // Clear and request together; the request lands after the sweep
    @(posedge clk);
    #1;
    addr_a[1] = 4'd9;
    data_a[1] = 16'h1234;
    run_clear(4'b0010);
    @(negedge clk);
    #1;
    check("reg9_after_clr", 32'(rf_mem[9]), 32'h1234);

    // Reset in the middle of a clear
    @(posedge clk);
    #1;
    preload(16'h2000);
    clear_start = 1'b1;
    for (int a = 0; a < 8; a++) exp_q.push_back('{a: 4'(a), d: 16'h0});
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort_addr", 32'(rf_address), 32'(c));
    end
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_wr", 32'(rf_write), 32'h0);
    check("abort_done", 32'(clear_done), 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int a = 8; a < 16; a++) check("abort_keep", 32'(rf_mem[a]), 32'h2000 + 32'(a));
    @(posedge clk);
    #1;
    addr_a[2] = 4'd3;
    data_a[2] = 16'hCAFE;
    req_v     = 4'b0100;
    grant_step(4'b0100);
    @(negedge clk);
    #1;
    check("reg3_after_rst", 32'(rf_mem[3]), 32'hCAFE);
    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
